// File: rtl/pc_fetch_pkg.sv
// Shared constants for the instruction-fetch front end: control polarities and
// fetch FSM state encodings, also used by the jump/flush controller.
package pc_fetch_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic PC_JUMP       = 1'b1;
  localparam logic CLEAR_ENABLE  = 1'b1;
  localparam logic CLEAR_DISABLE = 1'b0;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

endpackage

// File: rtl/pc_skid_buf.sv
// One-entry {inst, pc} holding buffer that catches an instruction returned by
// memory while the decode stage is stalled.
module pc_skid_buf
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              full,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush == CLEAR_ENABLE) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only ever read while full=1, so
  // leaving it unreset saves reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (load) begin
      out_inst <= in_inst;
      out_pc   <= in_pc;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, talks to instruction memory, hands
// one instruction per cycle to IF/ID, and handles redirects from execute.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              pc_jump_en
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] stale_pc;
  logic [ADDR_W-1:0] redir_pc;

  logic              in_reset;
  logic              ack;
  logic              buf_load;
  logic              buf_unload;
  logic              buf_flush;
  logic              buf_full;
  logic [INST_W-1:0] buf_inst;
  logic [ADDR_W-1:0] buf_pc;

  assign in_reset   = (rst == RST_ENABLE);
  assign imem_req   = !in_reset && (state != S_FULL);
  assign imem_addr  = (state == S_DRAIN) ? stale_pc : pc;
  assign ack        = imem_ack && imem_req;
  assign pc_jump_en = (jump_req && !in_reset) ? PC_JUMP : ~PC_JUMP;

  // A redirect always wins over stall, so the buffer only moves on quiet cycles.
  assign buf_load   = !in_reset && !jump_req && (state == S_RUN) && ack && stall;
  assign buf_unload = !in_reset && !jump_req && buf_full && !stall;
  assign buf_flush  = jump_req ? CLEAR_ENABLE : CLEAR_DISABLE;

  pc_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .unload   (buf_unload),
    .flush    (buf_flush),
    .in_inst  (imem_rdata),
    .in_pc    (pc),
    .full     (buf_full),
    .out_inst (buf_inst),
    .out_pc   (buf_pc)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      stale_pc   <= '0;
      redir_pc   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (jump_req) begin
      inst_valid <= 1'b0;
      case (state)
        S_DRAIN: begin
          redir_pc <= jump_target;
          if (ack) begin
            pc    <= jump_target;
            state <= S_RUN;
          end
        end
        S_FULL: begin
          pc    <= jump_target;
          state <= S_RUN;
        end
        default: begin
          // An unacked request must stay on the bus, so retire it before jumping.
          if (ack) begin
            pc    <= jump_target;
            state <= S_RUN;
          end else begin
            stale_pc <= pc;
            redir_pc <= jump_target;
            state    <= S_DRAIN;
          end
        end
      endcase
    end else begin
      case (state)
        S_RUN: begin
          if (ack) begin
            pc <= pc + 1'b1;
            if (stall) begin
              state <= S_FULL;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
            end
          end else if (!stall) begin
            inst_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            inst       <= buf_inst;
            inst_pc    <= buf_pc;
            inst_valid <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            inst_valid <= 1'b0;
          end
          if (ack) begin
            pc    <= redir_pc;
            state <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table for the fetch, stall,
// redirect and reset corner cases, then random traffic against a reference model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_req;
  logic [15:0] jump_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        pc_jump_en;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch #(
    .ADDR_W   (16),
    .INST_W   (16),
    .RESET_PC (16'hFFFE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_req    (jump_req),
    .jump_target (jump_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_jump_en  (pc_jump_en)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address, so any word identifies its source.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  typedef struct {
    logic        rst, stall, jump;
    logic [15:0] tgt;
    logic        ack, chk;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_jen, exp_valid;
    logic [15:0] exp_ipc;
    logic        zero_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, j, input logic [15:0] t, input logic a, c,
                     input logic e_req, input logic [15:0] e_addr, input logic e_jen,
                     input logic e_valid, input logic [15:0] e_ipc, input logic z);
    vec_t v;
    v.rst = r; v.stall = s; v.jump = j; v.tgt = t; v.ack = a; v.chk = c;
    v.exp_req = e_req; v.exp_addr = e_addr; v.exp_jen = e_jen;
    v.exp_valid = e_valid; v.exp_ipc = e_ipc; v.zero_inst = z;
    vecs.push_back(v);
  endtask

  // Reference model state: abstract fetcher view.
  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fetch_t;

  fetch_t      m_buf[$];
  logic [15:0] m_pc, m_stale, m_redir;
  logic        m_draining;
  logic        m_valid;
  logic [15:0] m_inst, m_ipc;

  initial begin
    rst = 1'b1; stall = 1'b0; jump_req = 1'b0; jump_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    //   rst stall jump tgt      ack chk | req addr     jen valid ipc      zero_inst
    add(1, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 0);
    add(1, 1, 1, 16'h1234, 0, 1,   0, 16'hFFFE, 0, 0, 16'h0000, 1); // reset beats jump
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'hFFFE, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'hFFFF, 0, 1, 16'hFFFE, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0000, 0, 1, 16'hFFFF, 0); // wrap
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0001, 0, 0, 16'h0000, 0); // bubble
    add(0, 0, 1, 16'h000E, 1, 1,   1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h000E, 0, 0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h000F, 0, 1, 16'h000E, 0);
    add(0, 1, 0, 16'h0000, 1, 1,   1, 16'h0010, 0, 1, 16'h000F, 0); // 0x10 buffered
    add(0, 1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 1, 16'h000F, 0);
    add(0, 1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 1, 16'h000F, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 1, 16'h000F, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0011, 0, 1, 16'h0010, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0012, 0, 1, 16'h0011, 0);
    add(0, 0, 1, 16'h0040, 1, 1,   1, 16'h0012, 1, 0, 16'h0011, 0); // zero-wait jump
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0040, 0, 0, 16'h0011, 0);
    add(0, 0, 1, 16'h0020, 1, 1,   1, 16'h0041, 1, 1, 16'h0040, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0020, 0, 0, 16'h0040, 0);
    add(0, 0, 1, 16'h0080, 0, 1,   1, 16'h0020, 1, 0, 16'h0040, 0); // delayed-ack jump
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0020, 0, 0, 16'h0040, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0020, 0, 0, 16'h0040, 0);
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0080, 0, 0, 16'h0040, 0);
    add(0, 1, 0, 16'h0000, 1, 1,   1, 16'h0081, 0, 1, 16'h0080, 0); // 0x81 buffered
    add(0, 1, 1, 16'h0033, 0, 1,   0, 16'h0000, 1, 1, 16'h0080, 0); // jump in full
    add(0, 1, 0, 16'h0000, 1, 1,   1, 16'h0033, 0, 0, 16'h0080, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0080, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0034, 0, 1, 16'h0033, 0);
    add(0, 0, 1, 16'h0077, 0, 1,   1, 16'h0034, 1, 0, 16'h0033, 0);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'h0034, 0, 0, 16'h0033, 0); // draining
    add(1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0033, 0); // reset mid-drain
    add(0, 0, 0, 16'h0000, 1, 1,   1, 16'hFFFE, 0, 0, 16'h0000, 1);
    add(0, 0, 0, 16'h0000, 0, 1,   1, 16'hFFFF, 0, 1, 16'hFFFE, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      stall       = vecs[i].stall;
      jump_req    = vecs[i].jump;
      jump_target = vecs[i].tgt;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].ack ? mem_word(imem_addr) : 16'hDEAD;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d imem_req", i), 16'(imem_req), 16'(vecs[i].exp_req));
        if (vecs[i].exp_req)
          check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d pc_jump_en", i), 16'(pc_jump_en), 16'(vecs[i].exp_jen));
        check($sformatf("v%0d inst_valid", i), 16'(inst_valid), 16'(vecs[i].exp_valid));
        check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].exp_ipc);
        if (vecs[i].exp_valid)
          check($sformatf("v%0d inst", i), inst, mem_word(vecs[i].exp_ipc));
        if (vecs[i].zero_inst)
          check($sformatf("v%0d inst_rst", i), inst, 16'h0000);
      end
    end

    // Random traffic: the first cycle is a reset that aligns model and DUT.
    m_pc = '0; m_stale = '0; m_redir = '0; m_draining = 1'b0;
    m_valid = 1'b0; m_inst = '0; m_ipc = '0;
    for (int c = 0; c < 600; c++) begin
      logic        r_rst, r_stall, r_jump, r_ack, e_req, had_buf;
      logic [15:0] r_tgt, r_data, e_addr;
      fetch_t      f;
      @(negedge clk);
      r_rst   = (c == 0) || ($urandom_range(0, 49) == 0);
      r_stall = ($urandom_range(0, 2) == 0);
      r_jump  = ($urandom_range(0, 5) == 0);
      r_tgt   = 16'($urandom);
      e_req   = !r_rst && (m_buf.size() == 0);
      e_addr  = m_draining ? m_stale : m_pc;
      r_ack   = e_req && ($urandom_range(0, 2) != 0);
      r_data  = r_ack ? mem_word(imem_addr) : 16'($urandom);
      rst = r_rst; stall = r_stall; jump_req = r_jump; jump_target = r_tgt;
      imem_ack = r_ack; imem_rdata = r_data;
      #1;
      if (c > 0) begin
        check("rnd imem_req", 16'(imem_req), 16'(e_req));
        if (e_req) check("rnd imem_addr", imem_addr, e_addr);
        check("rnd pc_jump_en", 16'(pc_jump_en), 16'(r_jump && !r_rst));
        check("rnd inst_valid", 16'(inst_valid), 16'(m_valid));
        check("rnd inst_pc", inst_pc, m_ipc);
        check("rnd inst", inst, m_inst);
      end
      @(posedge clk);
      had_buf = (m_buf.size() != 0);
      if (r_rst) begin
        m_pc = 16'hFFFE; m_draining = 1'b0; m_buf.delete();
        m_valid = 1'b0; m_inst = '0; m_ipc = '0;
      end else if (r_jump) begin
        m_valid = 1'b0;
        m_buf.delete();
        if (m_draining) begin
          m_redir = r_tgt;
          if (r_ack) begin m_pc = r_tgt; m_draining = 1'b0; end
        end else if (had_buf || r_ack) begin
          m_pc = r_tgt;
        end else begin
          m_stale = m_pc; m_redir = r_tgt; m_draining = 1'b1;
        end
      end else if (m_draining) begin
        if (!r_stall) m_valid = 1'b0;
        if (r_ack) begin m_pc = m_redir; m_draining = 1'b0; end
      end else if (had_buf) begin
        if (!r_stall) begin
          f = m_buf.pop_front();
          m_inst = f.inst; m_ipc = f.pc; m_valid = 1'b1;
        end
      end else if (r_ack) begin
        if (r_stall) begin
          f.inst = r_data; f.pc = m_pc;
          m_buf.push_back(f);
        end else begin
          m_inst = r_data; m_ipc = m_pc; m_valid = 1'b1;
        end
        m_pc = m_pc + 16'd1;
      end else if (!r_stall) begin
        m_valid = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
